// File: rtl/rx_csum_fifo_pkg.sv
// ---------------------------------------------------------------------------
// Module : rx_csum_fifo_pkg
// Shared checksum entry layout and write-select encoding for rx_csum_fifo.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rx_csum_fifo_pkg;

  localparam int CSUM_WIDTH       = 16;
  localparam int CSUM_ENTRY_WIDTH = 17;
  localparam int CSUM_BAD_BIT     = 16;

  typedef logic [CSUM_ENTRY_WIDTH-1:0] csum_entry_t;

  localparam csum_entry_t CSUM_PLACEHOLDER = {1'b1, 16'h0000};

  typedef enum logic [1:0] {
    WR_NONE        = 2'd0,
    WR_GOOD        = 2'd1,
    WR_PLACEHOLDER = 2'd2
  } wr_sel_e;

  function automatic csum_entry_t make_entry(input logic [CSUM_WIDTH-1:0] csum);
    return {1'b0, csum};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_csum_ram.sv
// ---------------------------------------------------------------------------
// Module : rx_csum_ram
// Simple dual-port checksum store, one write port and one registered read port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rx_csum_ram
  import rx_csum_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [CSUM_ENTRY_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [CSUM_ENTRY_WIDTH-1:0] o_rd_data
);

  // Addressed over the full pointer range so pointers can wrap freely;
  // the controller never holds more than 2**ADDR_WIDTH-1 words here.
  csum_entry_t r_mem [2**ADDR_WIDTH];
  csum_entry_t r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/rx_csum_fifo.sv
// ---------------------------------------------------------------------------
// Module : rx_csum_fifo
// Per-frame RX checksum buffer with drop-marker insertion on overflow.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rx_csum_fifo
  import rx_csum_fifo_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               s_axis_csum,
  input  logic                      s_axis_csum_valid,
  output logic [15:0]               m_axis_csum,
  output logic                      m_axis_csum_bad,
  output logic                      m_axis_csum_valid,
  input  logic                      m_axis_csum_ready,
  input  logic                      clear_overflow,
  output logic [$clog2(DEPTH):0]    status_count,
  output logic [DROP_CNT_WIDTH-1:0] status_pending_drop,
  output logic                      status_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]             C_DEPTH    = CW'(DEPTH);
  localparam logic [DROP_CNT_WIDTH-1:0] C_PEND_MAX = '1;
  localparam logic [DROP_CNT_WIDTH-1:0] C_PEND_ONE = DROP_CNT_WIDTH'(1);

  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [DROP_CNT_WIDTH-1:0] r_pending;
  logic                      r_overflow;
  logic                      r_out_valid;

  logic                      w_pop;
  logic                      w_space;
  logic                      w_ram_nonempty;
  logic                      w_load;
  logic                      w_wr_en;
  logic                      w_sat_hit;
  logic [DROP_CNT_WIDTH-1:0] w_pending_nxt;
  wr_sel_e                   w_wr_sel;
  csum_entry_t               w_wr_data;
  csum_entry_t               w_rd_data;

  assign w_pop   = r_out_valid & m_axis_csum_ready;
  assign w_space = (r_count < C_DEPTH) | w_pop;

  // Once a drop is owed, every new frame is also dropped until the debt is
  // paid, otherwise a good entry would overtake the drop markers ahead of it.
  always_comb begin
    w_wr_sel      = WR_NONE;
    w_pending_nxt = r_pending;
    w_sat_hit     = 1'b0;
    if (r_pending == '0) begin
      if (s_axis_csum_valid) begin
        if (w_space) begin
          w_wr_sel = WR_GOOD;
        end else begin
          w_pending_nxt = C_PEND_ONE;
        end
      end
    end else if (w_space) begin
      w_wr_sel = WR_PLACEHOLDER;
      if (!s_axis_csum_valid) begin
        w_pending_nxt = r_pending - C_PEND_ONE;
      end
    end else if (s_axis_csum_valid) begin
      if (r_pending == C_PEND_MAX) begin
        w_sat_hit = 1'b1;
      end else begin
        w_pending_nxt = r_pending + C_PEND_ONE;
      end
    end
  end

  assign w_wr_en   = (w_wr_sel != WR_NONE);
  assign w_wr_data = (w_wr_sel == WR_PLACEHOLDER) ? CSUM_PLACEHOLDER
                                                  : make_entry(s_axis_csum);

  // RAM occupancy is count minus the output register; the RAM read register
  // doubles as the output register, so a load is just a RAM read.
  assign w_ram_nonempty = (r_count != {{(CW-1){1'b0}}, r_out_valid});
  assign w_load         = w_ram_nonempty & (~r_out_valid | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_pending <= w_pending_nxt;
      if (w_sat_hit) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  rx_csum_ram #(
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_load),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign m_axis_csum_valid   = r_out_valid;
  assign m_axis_csum         = r_out_valid ? w_rd_data[CSUM_WIDTH-1:0] : '0;
  assign m_axis_csum_bad     = r_out_valid & w_rd_data[CSUM_BAD_BIT];
  assign status_count        = r_count;
  assign status_pending_drop = r_pending;
  assign status_overflow     = r_overflow;

endmodule

`default_nettype wire
